valu_wb_queue: RTL and testbench



---
 rtl/valu_wb_queue.sv | 160 ++++++++++++++++
 tb/tb_valu_wb_queue.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_wb_queue.sv
// -----------------------------------------------------------------------------
// valu_wb_queue
// Writeback result queue that sits after the fixed-latency vector ALU units.
// The ALUs cannot be stalled, so every returning result {vec, addr} is captured
// here and drained to the vector register file write port with valid/ready.
// An in-flight counter tracks ops issued but not yet returned. credit_ok tells
// the issue stage whether the queue could still absorb one more op.
//
// Optional build macro:
//   VALU_WB_BYPASS_EN - zero-latency bypass. When the queue is empty, an
//                       arriving result is presented on wb_* in the same cycle
//                       and is not stored if wb_ready accepts it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_issue            issue stage dispatched one op to the ALU this cycle
//   in_valid/vec/addr   ALU result
//   wb_valid/ready      head entry handshake toward the register file
//   wb_vec/wb_addr      head entry (zero when nothing is presented)
//   credit_ok           issue permitted this cycle
//   count               current queue occupancy
//   overflow            sticky: a result was dropped because the queue was full
//   protocol_err        sticky: a result arrived with nothing in flight
// -----------------------------------------------------------------------------
module valu_wb_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_issue,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_vec,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  credit_ok,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  protocol_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH:0]   DEPTH_W = (CNT_WIDTH + 1)'(DEPTH);

    logic [ENT_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_inflight;
    logic                 r_overflow;
    logic                 r_protocol_err;

    logic                 w_empty;
    logic                 w_full;
    logic [ENT_W-1:0]     w_head;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_bypass_take;
    logic [CNT_WIDTH:0]   w_committed;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    // First-word-fall-through: the head entry is read combinationally so it
    // is visible the cycle after it was written.
    assign w_head  = r_mem[r_rptr];

`ifdef VALU_WB_BYPASS_EN
    // Empty queue: forward the arriving result straight to the write port.
    assign wb_valid      = ~w_empty | in_valid;
    assign wb_vec        = ~w_empty ? w_head[ENT_W-1:ADDR_WIDTH]
                         : (in_valid ? in_vec : '0);
    assign wb_addr       = ~w_empty ? w_head[ADDR_WIDTH-1:0]
                         : (in_valid ? in_addr : '0);
    assign w_bypass_take = w_empty & in_valid & wb_ready;
`else
    assign wb_valid      = ~w_empty;
    assign wb_vec        = w_empty ? '0 : w_head[ENT_W-1:ADDR_WIDTH];
    assign wb_addr       = w_empty ? '0 : w_head[ADDR_WIDTH-1:0];
    assign w_bypass_take = 1'b0;
`endif

    // A pop only ever removes a stored entry; a bypassed result never touches
    // the storage.
    assign w_pop  = ~w_empty & wb_ready;
    // A full queue still accepts a result when the head leaves in the same
    // cycle, since the freed slot is the one being reused.
    assign w_push = in_valid & ~w_bypass_take & (~w_full | w_pop);
    assign w_drop = in_valid & w_full & ~w_pop;

    // One extra bit so count + in-flight cannot wrap.
    assign w_committed = {1'b0, r_count} + {1'b0, r_inflight};
    assign credit_ok   = (w_committed < DEPTH_W);

    assign count        = r_count;
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

    // Storage has no reset: validity is carried entirely by the pointers and
    // count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_vec, in_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_inflight     <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case ({in_issue, in_valid})
                2'b10: begin
                    // Saturate: an illegal issue must not wrap the counter.
                    if (r_inflight != DEPTH_C) begin
                        r_inflight <= r_inflight + 1'b1;
                    end
                end
                2'b01: begin
                    if (r_inflight == '0) begin
                        r_protocol_err <= 1'b1;
                    end else begin
                        r_inflight <= r_inflight - 1'b1;
                    end
                end
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_valu_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_valu_wb_queue
// Self-checking bench for valu_wb_queue. Every result driven into the queue
// that is expected to survive is pushed onto a scoreboard; each accepted
// writeback is popped and compared. Scenario tasks add inline checks of
// occupancy, credit and sticky flags.
// -----------------------------------------------------------------------------
module tb_valu_wb_queue;

    localparam int DW    = 64;
    localparam int AW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_issue = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_vec = '0;
    logic [AW-1:0] in_addr = '0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [DW-1:0] wb_vec;
    logic [AW-1:0] wb_addr;
    logic          credit_ok;
    logic [CW-1:0] count;
    logic          overflow;
    logic          protocol_err;

    logic [DW+AW-1:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    valu_wb_queue #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_issue    (in_issue),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .in_addr     (in_addr),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_vec      (wb_vec),
        .wb_addr     (wb_addr),
        .credit_ok   (credit_ok),
        .count       (count),
        .overflow    (overflow),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Advance one clock. Any writeback accepted at this edge is compared
    // against the scoreboard at the preceding negedge. Single-cycle pulses are
    // cleared 1 time unit after the edge.
    task automatic cycle();
        logic [DW+AW-1:0] exp_ent;
        @(negedge clk);
        if (wb_valid && wb_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got vec=%h addr=%h, required no writeback", wb_vec, wb_addr);
            end else begin
                exp_ent = sb.pop_front();
                if ({wb_vec, wb_addr} !== exp_ent) begin
                    n_fail++;
                    $display("FAIL sb_data: got vec=%h addr=%h, required vec=%h addr=%h",
                             wb_vec, wb_addr, exp_ent[DW+AW-1:AW], exp_ent[AW-1:0]);
                end else begin
                    $display("wb  vec=%h addr=%h", wb_vec, wb_addr);
                end
            end
        end
        @(posedge clk);
        #1;
        in_issue = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic issue_op();
        in_issue = 1'b1;
        cycle();
    endtask

    task automatic send_result(input logic [DW-1:0] v, input logic [AW-1:0] a, input bit kept);
        in_valid = 1'b1;
        in_vec   = v;
        in_addr  = a;
        if (kept) sb.push_back({v, a});
        cycle();
    endtask

    task automatic drain();
        int budget;
        wb_ready = 1'b1;
        budget   = 4 * DEPTH;
        while (sb.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d entries still expected, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        wb_ready = 1'b0;
        rst      = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_ready = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid: got %b required 0", wb_valid); end
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", count); end
        n_checks++; if (wb_vec !== '0 || wb_addr !== '0) begin n_fail++; $display("FAIL rst_wb_data: got %h/%h required 0/0", wb_vec, wb_addr); end
        n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("FAIL rst_credit: got %b required 1", credit_ok); end
        n_checks++; if (overflow !== 1'b0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got ovf=%b perr=%b required 0/0", overflow, protocol_err); end
    endtask

    task automatic test_single_op();
        issue_op();
        repeat (5) cycle();
        wb_ready = 1'b1;
        send_result(64'hA5A5, 32'h10, 1'b1);
`ifndef VALU_WB_BYPASS_EN
        n_checks++; if (wb_valid !== 1'b1 || count !== CW'(1)) begin n_fail++; $display("FAIL single_latency: got valid=%b count=%0d required 1/1", wb_valid, count); end
        n_checks++; if (wb_vec !== 64'hA5A5 || wb_addr !== 32'h10) begin n_fail++; $display("FAIL single_head: got %h/%h required a5a5/10", wb_vec, wb_addr); end
        cycle();
`endif
        n_checks++; if (count !== '0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got count=%0d valid=%b required 0/0", count, wb_valid); end
        n_checks++; if (credit_ok !== 1'b1 || sb.size() != 0) begin n_fail++; $display("FAIL single_credit: got credit=%b pending=%0d required 1/0", credit_ok, sb.size()); end
    endtask

    task automatic test_backpressure_fill();
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("FAIL fill_credit_pre%0d: got %b required 1", i, credit_ok); end
            issue_op();
        end
        n_checks++; if (credit_ok !== 1'b0) begin n_fail++; $display("FAIL fill_credit_full: got %b required 0", credit_ok); end
        for (int i = 1; i <= DEPTH; i++) begin
            send_result(DW'(i), AW'(32'h100 + i), 1'b1);
            n_checks++; if (count !== CW'(i) || credit_ok !== 1'b0) begin n_fail++; $display("FAIL fill_count%0d: got count=%0d credit=%b required %0d/0", i, count, credit_ok, i); end
        end
        drain();
        n_checks++; if (overflow !== 1'b0 || count !== '0 || credit_ok !== 1'b1) begin n_fail++; $display("FAIL fill_after: got ovf=%b count=%0d credit=%b required 0/0/1", overflow, count, credit_ok); end
    endtask

    task automatic test_overflow();
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) issue_op();
        for (int i = 0; i < DEPTH; i++) send_result(DW'(8'h11 + i), AW'(32'h200 + i), 1'b1);
        // Issue against the credit so the forced result is not also a
        // protocol error.
        issue_op();
        send_result(64'h99, 32'h999, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        n_checks++; if (count !== CW'(DEPTH) || protocol_err !== 1'b0) begin n_fail++; $display("FAIL ovf_count: got count=%0d perr=%b required 8/0", count, protocol_err); end
        drain();
        n_checks++; if (overflow !== 1'b1 || count !== '0) begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b count=%0d required 1/0", overflow, count); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) issue_op();
        for (int i = 0; i < DEPTH; i++) send_result(DW'(8'h21 + i), AW'(32'h300 + i), 1'b1);
        issue_op();
        wb_ready = 1'b1;
        send_result(64'h55, 32'h355, 1'b1);
        n_checks++; if (count !== CW'(DEPTH) || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_count: got count=%0d ovf=%b required 8/0", count, overflow); end
        drain();
        n_checks++; if (count !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL fullpp_after: got count=%0d ovf=%b required 0/0", count, overflow); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        wb_ready = 1'b1;
        send_result(64'hDEAD, 32'h44, 1'b1);
        n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag: got %b required 1", protocol_err); end
        drain();
        // In-flight must still be 0: exactly DEPTH issues are needed to close
        // the credit.
        wb_ready = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) issue_op();
        n_checks++; if (credit_ok !== 1'b1) begin n_fail++; $display("FAIL perr_inflight7: got credit=%b required 1", credit_ok); end
        issue_op();
        n_checks++; if (credit_ok !== 1'b0 || protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_inflight8: got credit=%b perr=%b required 0/1", credit_ok, protocol_err); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int i = 0; i < 5; i++) issue_op();
        for (int i = 0; i < 5; i++) send_result(DW'(8'h40 + i), AW'(32'h400 + i), 1'b1);
        n_checks++; if (count !== CW'(5)) begin n_fail++; $display("FAIL midrst_pre: got count=%0d required 5", count); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb.delete();
        n_checks++; if (wb_valid !== 1'b0 || count !== '0) begin n_fail++; $display("FAIL midrst_empty: got valid=%b count=%0d required 0/0", wb_valid, count); end
        n_checks++; if (credit_ok !== 1'b1 || overflow !== 1'b0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got credit=%b ovf=%b perr=%b required 1/0/0", credit_ok, overflow, protocol_err); end
`ifdef VALU_WB_BYPASS_EN
        wb_ready = 1'b1;
        in_valid = 1'b1;
        in_vec   = 64'hB0B0;
        in_addr  = 32'h77;
        #1;
        n_checks++; if (wb_valid !== 1'b1 || wb_vec !== 64'hB0B0) begin n_fail++; $display("FAIL bypass_same_cycle: got valid=%b vec=%h required 1/b0b0", wb_valid, wb_vec); end
        sb.push_back({64'hB0B0, 32'h77});
        cycle();
        n_checks++; if (count !== '0 || sb.size() != 0) begin n_fail++; $display("FAIL bypass_count: got count=%0d pending=%0d required 0/0", count, sb.size()); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        wb_ready = 1'b1;
        issue_op();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            in_issue = (i < 3 * DEPTH - 1);
            send_result(DW'(64'hC000 + i), AW'(32'h500 + i), 1'b1);
            n_checks++; if (count > CW'(1)) begin n_fail++; $display("FAIL b2b_count%0d: got %0d required <=1", i, count); end
        end
        drain();
        n_checks++; if (credit_ok !== 1'b1 || protocol_err !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_after: got credit=%b perr=%b ovf=%b required 1/0/0", credit_ok, protocol_err, overflow); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_backpressure_fill();
        test_overflow();
        test_full_push_pop();
        test_protocol_err();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
